// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit BCD add sequencer: one digit per clock, LSD first, carry held in a register.
// Optional BCD_SUB_EN adds a `sub` port for ten's-complement subtraction (A-B).
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in1,
  input  logic [4*DIGITS-1:0]   in2,
  input  logic                  carry_in,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry_out,
  output logic                  err_digit,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [4*DIGITS-1:0]   a_r;
  logic [4*DIGITS-1:0]   b_r;
  logic [4*DIGITS-1:0]   sum_r;
  logic [4*DIGITS-1:0]   sum_next_s;
  logic [CNT_W-1:0]      cnt_r;
  logic                  carry_r;
  logic                  carry_out_r;
  logic                  err_r;
  logic                  out_valid_r;
  logic                  in_ready_r;
  logic                  busy_r;
  logic                  sub_mode_s;
  logic                  last_s;
  logic [3:0]            a_dig_s;
  logic [3:0]            b_raw_s;
  logic [3:0]            b_dig_s;
  logic [4:0]            add_s;

  // Single BCD digit add: returns {carry, digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic c);
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    if (t > 5'd9) begin
      bcd_digit_add = {1'b1, t[3:0] + 4'd6};
    end else begin
      bcd_digit_add = {1'b0, t[3:0]};
    end
  endfunction

  function automatic logic bad_digit(input logic [3:0] d);
    bad_digit = (d > 4'd9);
  endfunction

`ifdef BCD_SUB_EN
  logic sub_r;
  assign sub_mode_s = sub_r;
`else
  assign sub_mode_s = 1'b0;
`endif

  assign last_s = (cnt_r == CNT_W'(DIGITS - 1));

  // Digit selection, digit add, in-place sum update and next-state decode.
  always_comb begin
    state_next_s = state_r;
    a_dig_s      = 4'd0;
    b_raw_s      = 4'd0;
    sum_next_s   = sum_r;
    for (int i = 0; i < DIGITS; i++) begin
      a_dig_s = (cnt_r == CNT_W'(i)) ? a_r[4*i +: 4] : a_dig_s;
      b_raw_s = (cnt_r == CNT_W'(i)) ? b_r[4*i +: 4] : b_raw_s;
    end
    b_dig_s = sub_mode_s ? (4'd9 - b_raw_s) : b_raw_s;
    add_s   = bcd_digit_add(a_dig_s, b_dig_s, carry_r);
    for (int i = 0; i < DIGITS; i++) begin
      sum_next_s[4*i +: 4] = (cnt_r == CNT_W'(i)) ? add_s[3:0] : sum_r[4*i +: 4];
    end
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_ADD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ADD;
        end
      end
      ST_DONE: begin
        if (out_valid_r && out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs; out_valid trails the DONE entry by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      carry_out_r <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
`ifdef BCD_SUB_EN
      sub_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      busy_r      <= (state_next_s == ST_ADD);
      out_valid_r <= (state_r == ST_DONE) && !(out_valid_r && out_ready);
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r   <= in1;
            b_r   <= in2;
            sum_r <= '0;
            err_r <= 1'b0;
            cnt_r <= '0;
`ifdef BCD_SUB_EN
            sub_r   <= sub;
            carry_r <= sub ? 1'b1 : carry_in;
`else
            carry_r <= carry_in;
`endif
          end
        end
        ST_ADD: begin
          sum_r   <= sum_next_s;
          carry_r <= add_s[4];
          // Error flag looks at the raw operand digits, never the complemented B.
          err_r   <= err_r | bad_digit(a_dig_s) | bad_digit(b_raw_s);
          if (last_s) begin
            carry_out_r <= add_s[4];
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign err_digit = err_r;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed, table-driven bench for bcd_serial_add_ctrl (DIGITS=4).
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry_out;
  logic        err_digit;
  logic        busy;
`ifdef BCD_SUB_EN
  logic        sub;
`endif

  int nchk = 0;
  int nerr = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .carry_in (carry_in),
`ifdef BCD_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .err_digit(err_digit),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] es;
    logic        ec;
    logic        ee;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full transaction with out_ready held high; called at a negedge, returns at a negedge.
  task automatic do_op(input vec_t v);
    int lat;
    out_ready = 1'b1;
    in1       = v.a;
    in2       = v.b;
    carry_in  = v.ci;
`ifdef BCD_SUB_EN
    sub       = v.sb;
`endif
    in_valid  = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in1      = 16'hFFFF;
    in2      = 16'hFFFF;
    carry_in = ~v.ci;
    chk("busy_after_accept", {30'd0, busy, in_ready}, 32'd2);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, DIGITS + 1);
    chk("sum", {16'd0, sum}, {16'd0, v.es});
    chk("carry_out", {31'd0, carry_out}, {31'd0, v.ec});
    chk("err_digit", {31'd0, err_digit}, {31'd0, v.ee});
    @(posedge clk);
    @(negedge clk);
    chk("post_handshake", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in1       = 16'h0;
    in2       = 16'h0;
    carry_in  = 1'b0;
    out_ready = 1'b1;
`ifdef BCD_SUB_EN
    sub       = 1'b0;
`endif
    vecs.push_back('{16'h0009, 16'h0003, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b0});
    vecs.push_back('{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
    vecs.push_back('{16'h00A1, 16'h0001, 1'b0, 1'b0, 16'h0102, 1'b0, 1'b1});
    vecs.push_back('{16'h1234, 16'h8766, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0});
    vecs.push_back('{16'h5678, 16'h4321, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 16'h000B, 1'b0, 1'b0, 16'h0011, 1'b0, 1'b1});
`ifdef BCD_SUB_EN
    vecs.push_back('{16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0});
    vecs.push_back('{16'h0001, 16'h0002, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0});
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {13'd0, sum, carry_out, err_digit, out_valid, busy, in_ready}, 32'd1);

    foreach (vecs[i]) do_op(vecs[i]);

    // Backpressure: result must hold while out_ready is low; in_valid pulses ignored.
    out_ready = 1'b0;
    in1 = 16'h1234;
    in2 = 16'h1111;
    carry_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("bp_latency", lat, DIGITS + 1);
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in1      = 16'h9999;
      in2      = 16'h9999;
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold", {13'd0, sum, carry_out, out_valid, in_ready}, {13'd0, 16'h2345, 3'b010});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_no_queue", {14'd0, sum, busy, out_valid}, {14'd0, 16'h2345, 2'b00});

    // Reset in the second ADD cycle aborts the operation.
    in1 = 16'h4321;
    in2 = 16'h1111;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_outputs", {13'd0, sum, carry_out, err_digit, out_valid, busy, in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("midreset_no_result", {30'd0, out_valid, busy}, 32'd0);
    v = '{16'h0045, 16'h0055, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    do_op(v);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
